// File: rtl/ad_pkg.sv
// Definitions shared by the ADC acquisition path: the FSM state encoding and
// default parameter values.
package ad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StConvst,
    StWaitBusy,
    StShift,
    StDone
  } ad_state_e;

  localparam int unsigned DefDataW       = 16;
  localparam int unsigned DefSclkDiv     = 2;
  localparam int unsigned DefConvCycles  = 4;
  localparam int unsigned DefBusyTimeout = 255;

  // Width of a counter that must hold every value from 0 to n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adc_sclk_div.sv
// Serial clock generator for the ADC interface: idles low and toggles every
// SCLK_DIV cycles while run_i is high.
module adc_sclk_div import ad_pkg::*; #(
  parameter int unsigned SCLK_DIV = DefSclkDiv
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] HalfLast = 8'(SCLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       toggle;

  // The strobes mark the edge where sclk toggles, provided run_i is still high
  // there; they do not depend on run_i, so the caller may use them to drop run_i.
  assign toggle = (cnt_q == HalfLast);
  assign rise_o = toggle & ~sclk_q;
  assign fall_o = toggle & sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (toggle) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/adc_spi_rx.sv
// Single-sample ADC reader: pulses convst, waits for busy to clear, then clocks
// a DATA_W-bit frame in MSB first and hands it to the consumer.
module adc_spi_rx import ad_pkg::*; #(
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned SCLK_DIV     = DefSclkDiv,
  parameter int unsigned CONV_CYCLES  = DefConvCycles,
  parameter int unsigned BUSY_TIMEOUT = DefBusyTimeout
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              read_req_i,
  output logic              read_ready_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic              err_o,
  output logic              adc_convst_o,
  input  logic              adc_busy_i,
  output logic              adc_cs_n_o,
  output logic              adc_sclk_o,
  input  logic              adc_sdo_i
);

  localparam int unsigned     BitW     = cnt_width(DATA_W);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_W);
  localparam logic [7:0]      ConvLast = 8'(CONV_CYCLES - 1);
  localparam logic [7:0]      TmoLast  = 8'(BUSY_TIMEOUT - 1);

  ad_state_e         state_q;
  logic [7:0]        cnt_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] data_q;
  logic              convst_q;
  logic              cs_n_q;
  logic              ready_q;
  logic              err_q;
  logic              drop_q;
  logic              tail_q;

  logic sclk_rise;
  logic sclk_fall;
  logic sclk_run;
  logic in_shift;
  logic frame_end;

  // The frame closes on the rise that would follow the final low half-period,
  // so sclk is held low there and cs_n rises together with read_ready.
  assign in_shift  = (state_q == StShift);
  assign frame_end = in_shift & sclk_rise & tail_q;
  assign sclk_run  = in_shift & ~frame_end;

  adc_sclk_div #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk_div (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .run_i (sclk_run),
    .sclk_o(adc_sclk_o),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      convst_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      tail_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      // A request withdrawn mid-transaction still completes, but silently.
      if ((state_q inside {StConvst, StWaitBusy, StShift}) && !read_req_i) begin
        drop_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (read_req_i) begin
            state_q  <= StConvst;
            convst_q <= 1'b1;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
          end
        end
        StConvst: begin
          if (cnt_q == ConvLast) begin
            state_q  <= StWaitBusy;
            convst_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StWaitBusy: begin
          // cnt_q == 0 is the first cycle here, where busy may not be asserted yet.
          if ((cnt_q != 8'd0) && !adc_busy_i) begin
            state_q   <= StShift;
            cs_n_q    <= 1'b0;
            bit_cnt_q <= '0;
            tail_q    <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_q == TmoLast) begin
            state_q <= StDone;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StShift: begin
          if (frame_end) begin
            state_q <= StDone;
            cs_n_q  <= 1'b1;
            data_q  <= shreg_q;
            ready_q <= read_req_i & ~drop_q;
            tail_q  <= 1'b0;
          end else begin
            if (sclk_rise) begin
              shreg_q   <= DATA_W'({shreg_q, adc_sdo_i});
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
            if (sclk_fall && (bit_cnt_q == BitLast)) begin
              tail_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (!read_req_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign read_ready_o = ready_q;
  assign read_data_o  = data_q;
  assign err_o        = err_q;
  assign adc_convst_o = convst_q;
  assign adc_cs_n_o   = cs_n_q;

endmodule
